// File: rtl/dp_switch_pio_irq.sv
// Avalon-MM input PIO: synchronised switch inputs, per-bit edge capture, interrupt mask and level IRQ.
// Optional per-bit debounce filter is compiled in when DP_PIO_DEBOUNCE_EN is defined.
module dp_switch_pio_irq #(
    parameter int WIDTH           = 2,
    parameter int EDGE_TYPE       = 0,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev_reg;
    logic [WIDTH-1:0] irq_mask_reg;
    logic [WIDTH-1:0] edge_capture_reg;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] w1c_bits;
    logic [WIDTH-1:0] rd_sel;
    logic             wr_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    assign sync_out = sync_reg[SYNC_STAGES-1];

`ifdef DP_PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_debounce
            logic [CW-1:0] cnt_reg;
            logic          filt_bit_reg;

            // Any sample that agrees with the accepted value restarts the stability count.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg      <= '0;
                    filt_bit_reg <= 1'b0;
                end else if (sync_out[gi] == filt_bit_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
                    filt_bit_reg <= sync_out[gi];
                    cnt_reg      <= '0;
                end else if (cnt_reg != {CW{1'b1}}) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign filt[gi] = filt_bit_reg;
        end
    endgenerate
`else
    assign filt = sync_out;
`endif

    always_comb begin
        edge_det = filt ^ prev_reg;
        case (EDGE_TYPE)
            0:       edge_det = filt & ~prev_reg;
            1:       edge_det = ~filt & prev_reg;
            default: edge_det = filt ^ prev_reg;
        endcase
    end

    assign wr_en    = chipselect & ~write_n;
    assign w1c_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_sel = '0;
        case (address)
            2'd0:    rd_sel = filt;
            2'd2:    rd_sel = irq_mask_reg;
            2'd3:    rd_sel = edge_capture_reg;
            default: rd_sel = '0;
        endcase
    end

    // A fresh edge is OR-ed in after the clear, so it wins over a same-cycle W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_reg         <= '0;
            irq_mask_reg     <= '0;
            edge_capture_reg <= '0;
            readdata         <= '0;
        end else begin
            prev_reg         <= filt;
            edge_capture_reg <= (edge_capture_reg & ~w1c_bits) | edge_det;
            readdata         <= 32'(rd_sel);
            if (wr_en && address == 2'd2) begin
                irq_mask_reg <= writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(edge_capture_reg & irq_mask_reg);

    logic unused_writedata;
    assign unused_writedata = &{1'b0, writedata};

endmodule

// File: tb/tb_dp_switch_pio_irq.sv
// Directed self-checking bench for dp_switch_pio_irq (WIDTH=2, rising-edge capture, 2 sync stages).
// Define DP_PIO_DEBOUNCE_EN to also exercise the debounce filter with DEBOUNCE_CYCLES=8.
module tb_dp_switch_pio_irq;

`ifdef DP_PIO_DEBOUNCE_EN
    localparam int DB = 8;
`else
    localparam int DB = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [1:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    dp_switch_pio_irq #(
        .WIDTH(2),
        .EDGE_TYPE(0),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        address = a;
        @(posedge clk);
        #1;
        check_eq(tag, readdata, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic set_in(input logic [1:0] v);
        @(negedge clk);
        in_port = v;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 2'b00;
        #23;
        check_eq("rst_readdata", readdata, 32'h0);
        check_eq("rst_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: register map reads zero after reset
        rd(2'd0, 32'h0, "t1_data");
        rd(2'd2, 32'h0, "t1_mask");
        rd(2'd3, 32'h0, "t1_cap");
        check_eq("t1_irq", {31'h0, irq}, 32'h0);

`ifdef DP_PIO_DEBOUNCE_EN
        // 5: short glitch rejected, long level accepted
        set_in(2'b01);
        repeat (5) @(posedge clk);
        set_in(2'b00);
        wait_edges(20);
        rd(2'd0, 32'h0, "t5_glitch_data");
        rd(2'd3, 32'h0, "t5_glitch_cap");
        set_in(2'b10);
        wait_edges(12);
        rd(2'd0, 32'h2, "t5_level_data");
        rd(2'd3, 32'h2, "t5_level_cap");
        set_in(2'b00);
        wait_edges(20);
        wr(2'd3, 32'h3);
        rd(2'd3, 32'h0, "t5_cleanup_cap");
`endif

        // 2: latency of a rising edge on bit 0, mask still 0
        @(negedge clk);
        address = 2'd0;
        in_port = 2'b01;
        @(posedge clk);
        wait_edges(DB + 1);
        check_eq("t2_lat_early", readdata, 32'h0);
        wait_edges(1);
        check_eq("t2_lat_data", readdata, 32'h1);
        check_eq("t2_irq_masked", {31'h0, irq}, 32'h0);
        rd(2'd3, 32'h1, "t2_cap");

        // 3: unmask bit 0, falling edge ignored, rising edge raises irq, W1C drops it
        wr(2'd3, 32'h3);
        wr(2'd2, 32'h1);
        check_eq("t3_irq_after_clr", {31'h0, irq}, 32'h0);
        set_in(2'b00);
        wait_edges(6 + DB);
        check_eq("t3_fall_ignored", {31'h0, irq}, 32'h0);
        rd(2'd3, 32'h0, "t3_fall_cap");
        set_in(2'b01);
        wait_edges(3 + DB);
        check_eq("t3_irq_set", {31'h0, irq}, 32'h1);
        wr(2'd3, 32'h1);
        check_eq("t3_irq_clr", {31'h0, irq}, 32'h0);

        // 4: new edge and W1C of the same bit on the same clock
        set_in(2'b00);
        wait_edges(6 + DB);
        @(negedge clk);
        in_port = 2'b01;
        @(posedge clk);
        wait_edges(DB + 1);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'd3;
        writedata  = 32'h1;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        check_eq("t4_irq_kept", {31'h0, irq}, 32'h1);
        rd(2'd3, 32'h1, "t4_cap_kept");
        wr(2'd3, 32'h1);
        check_eq("t4_irq_clr", {31'h0, irq}, 32'h0);

        // bit 1 capture under mask, then unmask; ignored writes
        set_in(2'b11);
        wait_edges(4 + DB);
        rd(2'd3, 32'h2, "bit1_cap");
        check_eq("bit1_masked", {31'h0, irq}, 32'h0);
        wr(2'd2, 32'h3);
        check_eq("bit1_unmasked", {31'h0, irq}, 32'h1);
        rd(2'd2, 32'h3, "mask_readback");
        rd(2'd0, 32'h3, "data_both");
        wr(2'd0, 32'h0);
        rd(2'd0, 32'h3, "wr_addr0_ignored");
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, 32'h0, "rsv_reads_zero");

        // 6: asynchronous reset mid-operation with capture=3, mask=3
        set_in(2'b10);
        wait_edges(4 + DB);
        set_in(2'b11);
        wait_edges(4 + DB);
        rd(2'd3, 32'h3, "t6_cap_pre");
        check_eq("t6_irq_pre", {31'h0, irq}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t6_irq_async", {31'h0, irq}, 32'h0);
        check_eq("t6_readdata_async", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd2, 32'h0, "t6_mask_reset");
        wait_edges(4 + DB);
        rd(2'd3, 32'h3, "t6_rise_after_reset");
        check_eq("t6_irq_after_reset", {31'h0, irq}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
